uart_bus_master: RTL and testbench

Serial-driven bus initiator for debug and program loading. Consumes a byte stream (typically the UART rx FIFO), decodes read/write commands, and drives single-word accesses on the CPU memory bus (word `addr`, 4-bit `we`, `re`, 1-cycle registered read data) after obtaining the bus from the arbiter. Returns acknowledgements and read data as a byte stream toward the UART tx FIFO. Sits beside the CPU as a second initiator on the same RAM/peripheral map.

---
 rtl/uart_bus_master_pkg.sv | 23 ++
 rtl/byte_word_shifter.sv | 38 +++
 rtl/uart_bus_master.sv | 200 ++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_master_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the UART-driven bus master.
package uart_bus_master_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_REQ,
        S_ACCESS,
        S_CAPTURE,
        S_SEND
    } state_t;

    function automatic logic isOpcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/byte_word_shifter.sv
// 32-bit word register filled a byte at a time LSB-first and drained the same way,
// with a 2-bit byte count that flags the fourth byte.
module byte_word_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_shiftIn,
    input  logic [7:0]  i_byte,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_shiftOut,
    output logic [31:0] o_word,
    output logic        o_done
);

    logic [31:0] r_word;
    logic [1:0]  r_count;

    // A parallel load restarts the byte count so a full word can be drained next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_count <= '0;
        end else if (i_shiftIn) begin
            r_word  <= {i_byte, r_word[31:8]};
            r_count <= r_count + 2'd1;
        end else if (i_shiftOut) begin
            r_word  <= {8'h00, r_word[31:8]};
            r_count <= r_count + 2'd1;
        end
    end

    assign o_word = r_word;
    assign o_done = (r_count == 2'd3) && (i_shiftIn || i_shiftOut);

endmodule

// File: rtl/uart_bus_master.sv
// Byte-stream command decoder that takes the memory bus from the arbiter to perform
// single-word reads and writes, answering with ACK/NAK or four read-data bytes.
module uart_bus_master
    import uart_bus_master_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [29:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  we,
    output logic        re,
    input  logic [31:0] rdata,
    output logic        busy
);

    state_t      r_state;
    logic        r_isWrite;
    logic        r_multiByte;
    logic        r_rxReady;
    logic [7:0]  r_txData;
    logic        r_txValid;
    logic        r_busReq;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_we;
    logic        r_re;

    logic        w_rxFire;
    logic        w_txFire;
    logic        w_addrShift;
    logic        w_dataShiftIn;
    logic        w_dataLoad;
    logic        w_dataShiftOut;
    logic [31:0] w_addrWord;
    logic [31:0] w_dataWord;
    logic        w_addrDone;
    logic        w_dataDone;
    logic        w_misaligned;
    logic [1:0]  w_unusedAddrBits;

    assign w_rxFire       = rx_valid && r_rxReady;
    assign w_txFire       = r_txValid && tx_ready;
    assign w_addrShift    = (r_state == S_ADDR) && w_rxFire;
    assign w_dataShiftIn  = (r_state == S_DATA) && w_rxFire;
    assign w_dataLoad     = (r_state == S_CAPTURE);
    assign w_dataShiftOut = (r_state == S_SEND) && r_multiByte && w_txFire;

    // While the fourth address byte is arriving, the first byte sits in bits [15:8].
    assign w_misaligned     = (w_addrWord[9:8] != 2'b00);
    assign w_unusedAddrBits = w_addrWord[1:0];

    byte_word_shifter u_addrShifter (
        .clk        (clk),
        .reset      (reset),
        .i_shiftIn  (w_addrShift),
        .i_byte     (rx_data),
        .i_load     (1'b0),
        .i_word     (32'h0),
        .i_shiftOut (1'b0),
        .o_word     (w_addrWord),
        .o_done     (w_addrDone)
    );

    byte_word_shifter u_dataShifter (
        .clk        (clk),
        .reset      (reset),
        .i_shiftIn  (w_dataShiftIn),
        .i_byte     (rx_data),
        .i_load     (w_dataLoad),
        .i_word     (rdata),
        .i_shiftOut (w_dataShiftOut),
        .o_word     (w_dataWord),
        .o_done     (w_dataDone)
    );

    // Strobes default low every cycle so they can only pulse for the single ACCESS cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_isWrite   <= 1'b0;
            r_multiByte <= 1'b0;
            r_rxReady   <= 1'b0;
            r_txData    <= '0;
            r_txValid   <= 1'b0;
            r_busReq    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= '0;
            r_re        <= 1'b0;
        end else begin
            r_we <= '0;
            r_re <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_rxReady <= 1'b1;
                    if (w_rxFire) begin
                        if (isOpcode(rx_data)) begin
                            r_isWrite <= (rx_data == OP_WRITE);
                            r_state   <= S_ADDR;
                        end else begin
                            r_rxReady   <= 1'b0;
                            r_txData    <= NAK;
                            r_txValid   <= 1'b1;
                            r_multiByte <= 1'b0;
                            r_state     <= S_SEND;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_addrDone) begin
                        if (w_misaligned) begin
                            r_rxReady   <= 1'b0;
                            r_txData    <= NAK;
                            r_txValid   <= 1'b1;
                            r_multiByte <= 1'b0;
                            r_state     <= S_SEND;
                        end else if (r_isWrite) begin
                            r_state <= S_DATA;
                        end else begin
                            r_rxReady <= 1'b0;
                            r_busReq  <= 1'b1;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_DATA: begin
                    if (w_dataDone) begin
                        r_rxReady <= 1'b0;
                        r_busReq  <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        r_addr  <= w_addrWord[31:2];
                        r_state <= S_ACCESS;
                        if (r_isWrite) begin
                            r_wdata <= w_dataWord;
                            r_we    <= 4'b1111;
                        end else begin
                            r_re <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_isWrite) begin
                        r_busReq    <= 1'b0;
                        r_txData    <= ACK;
                        r_txValid   <= 1'b1;
                        r_multiByte <= 1'b0;
                        r_state     <= S_SEND;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_busReq    <= 1'b0;
                    r_txData    <= rdata[7:0];
                    r_txValid   <= 1'b1;
                    r_multiByte <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    // The next read byte comes from bits [15:8] as the shifter drops the accepted one.
                    if (w_txFire) begin
                        if (r_multiByte && !w_dataDone) begin
                            r_txData <= w_dataWord[15:8];
                        end else begin
                            r_txValid <= 1'b0;
                            r_rxReady <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready = r_rxReady;
    assign tx_data  = r_txData;
    assign tx_valid = r_txValid;
    assign bus_req  = r_busReq;
    assign addr     = r_addr;
    assign wdata    = r_wdata;
    assign we       = r_we;
    assign re       = r_re;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: a small word memory answers the bus and
// monitors record strobes and accepted tx bytes for comparison with hand-computed values.
module tb_uart_bus_master;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic [31:0] rdata;
    logic        busy;

    int          checkCount = 0;
    int          passCount  = 0;
    int          cycle      = 0;

    int          weCount = 0;
    int          reCount = 0;
    int          reqRises = 0;
    int          weCycle = 0;
    int          reCycle = 0;
    int          txRiseCycle = 0;
    int          stableErrs = 0;
    int          gntViolations = 0;
    logic [29:0] weAddr;
    logic [31:0] weData;
    logic [3:0]  weVal;
    logic [29:0] reAddr;
    logic        prevReq = 1'b0;
    logic        prevTxValid = 1'b0;
    logic        prevTxReady = 1'b0;
    logic [7:0]  prevTxData = 8'h00;

    logic [7:0]  txQ[$];
    logic [7:0]  cmdQ[$];
    logic [31:0] mem [0:15];

    uart_bus_master dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .rdata    (rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Word memory with byte enables and one-cycle registered read data.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr[3:0]][b*8 +: 8] = wdata[b*8 +: 8];
        end
        if (re) rdata <= mem[addr[3:0]];
    end

    // Observe the DUT mid-cycle: strobes, grant violations, tx hold rule and accepted bytes.
    always @(negedge clk) begin
        if (reset) begin
            if (we != 4'h0) begin
                weCount++;
                weAddr  = addr;
                weData  = wdata;
                weVal   = we;
                weCycle = cycle;
            end
            if (re) begin
                reCount++;
                reAddr  = addr;
                reCycle = cycle;
            end
            if (((we != 4'h0) || re) && !bus_gnt) gntViolations++;
            if (bus_req && !prevReq) reqRises++;
            if (tx_valid && !prevTxValid) txRiseCycle = cycle;
            if (prevTxValid && !prevTxReady && (!tx_valid || tx_data != prevTxData)) stableErrs++;
            if (tx_valid && tx_ready) txQ.push_back(tx_data);
        end
        prevReq     = bus_req;
        prevTxValid = tx_valid;
        prevTxReady = tx_ready;
        prevTxData  = tx_data;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Sends every byte in cmdQ, waiting (bounded) for rx_ready on each.
    task automatic applyStimulus();
        foreach (cmdQ[i]) begin
            int n = 0;
            tick();
            rx_data  = cmdQ[i];
            rx_valid = 1'b1;
            while (!rx_ready && n < 200) begin
                tick();
                n++;
            end
            checkOutput("rxAccept", {31'h0, rx_ready}, 32'h1);
            tick();
            rx_valid = 1'b0;
        end
    endtask

    task automatic waitTx(input int count);
        for (int n = 0; n < 200 && txQ.size() < count; n++) tick();
        checkOutput("txCount", txQ.size(), count);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".rx_ready"}, {31'h0, rx_ready}, 32'h0);
        checkOutput({tag, ".tx_valid"}, {31'h0, tx_valid}, 32'h0);
        checkOutput({tag, ".tx_data"},  {24'h0, tx_data},  32'h0);
        checkOutput({tag, ".bus_req"},  {31'h0, bus_req},  32'h0);
        checkOutput({tag, ".addr"},     {2'h0, addr},      32'h0);
        checkOutput({tag, ".wdata"},    wdata,             32'h0);
        checkOutput({tag, ".we"},       {28'h0, we},       32'h0);
        checkOutput({tag, ".re"},       {31'h0, re},       32'h0);
        checkOutput({tag, ".busy"},     {31'h0, busy},     32'h0);
    endtask

    initial begin
        logic [7:0] expRd[4];
        logic [7:0] expStall[4];
        int         weBefore;
        int         reBefore;
        int         reqBefore;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        bus_gnt  = 1'b1;
        rdata    = 32'h0;
        repeat (3) tick();
        checkResetValues("reset");
        reset = 1'b1;
        repeat (2) tick();

        $display("[TB] write command");
        txQ.delete();
        cmdQ = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        applyStimulus();
        waitTx(1);
        checkOutput("wr.ack",     {24'h0, txQ[0]}, 32'h06);
        checkOutput("wr.weCount", weCount, 1);
        checkOutput("wr.addr",    {2'h0, weAddr}, 32'h4);
        checkOutput("wr.wdata",   weData, 32'hDEADBEEF);
        checkOutput("wr.we",      {28'h0, weVal}, 32'hF);
        checkOutput("wr.ackLat",  txRiseCycle - weCycle, 1);
        checkOutput("wr.noRead",  reCount, 0);
        checkOutput("wr.mem",     mem[4], 32'hDEADBEEF);
        repeat (2) tick();
        checkOutput("wr.idle",    {31'h0, busy}, 32'h0);
        checkOutput("wr.reqDrop", {31'h0, bus_req}, 32'h0);

        $display("[TB] read command");
        mem[4] = 32'h12345678;
        expRd  = '{8'h78, 8'h56, 8'h34, 8'h12};
        txQ.delete();
        cmdQ = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        applyStimulus();
        waitTx(4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("rd.byte%0d", i), {24'h0, txQ[i]}, {24'h0, expRd[i]});
        checkOutput("rd.reCount", reCount, 1);
        checkOutput("rd.addr",    {2'h0, reAddr}, 32'h4);
        checkOutput("rd.txLat",   txRiseCycle - reCycle, 2);
        checkOutput("rd.noWrite", weCount, 1);

        $display("[TB] bad opcode");
        weBefore  = weCount;
        reBefore  = reCount;
        reqBefore = reqRises;
        txQ.delete();
        cmdQ = '{8'h41};
        applyStimulus();
        waitTx(1);
        checkOutput("op.nak",   {24'h0, txQ[0]}, 32'h15);
        checkOutput("op.noReq", reqRises, reqBefore);
        checkOutput("op.noAcc", weCount + reCount, weBefore + reBefore);

        $display("[TB] misaligned address");
        txQ.delete();
        cmdQ = '{8'h57, 8'h11, 8'h00, 8'h00, 8'h00};
        applyStimulus();
        waitTx(1);
        checkOutput("mis.nak",   {24'h0, txQ[0]}, 32'h15);
        checkOutput("mis.noReq", reqRises, reqBefore);
        checkOutput("mis.noWe",  weCount, weBefore);
        checkOutput("mis.noRe",  reCount, reBefore);

        $display("[TB] grant stall and tx backpressure");
        mem[8]   = 32'hA1B2C3D4;
        expStall = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        bus_gnt  = 1'b0;
        tx_ready = 1'b0;
        txQ.delete();
        cmdQ = '{8'h52, 8'h20, 8'h00, 8'h00, 8'h00};
        applyStimulus();
        repeat (20) tick();
        checkOutput("stall.req",     {31'h0, bus_req}, 32'h1);
        checkOutput("stall.busy",    {31'h0, busy}, 32'h1);
        checkOutput("stall.rxReady", {31'h0, rx_ready}, 32'h0);
        checkOutput("stall.noRe",    reCount, reBefore);
        bus_gnt = 1'b1;
        for (int i = 0; i < 200 && txQ.size() < 4; i++) begin
            tx_ready = ((i % 3) != 1) && ((i % 5) != 0);
            tick();
        end
        tx_ready = 1'b1;
        repeat (5) tick();
        checkOutput("stall.count", txQ.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("stall.byte%0d", i), {24'h0, txQ[i]}, {24'h0, expStall[i]});
        checkOutput("stall.addr",  {2'h0, reAddr}, 32'h8);

        $display("[TB] reset during data phase");
        weBefore = weCount;
        txQ.delete();
        cmdQ = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        applyStimulus();
        reset = 1'b0;
        tick();
        checkResetValues("midRst");
        reset = 1'b1;
        repeat (2) tick();
        cmdQ = '{8'h57, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        applyStimulus();
        waitTx(1);
        checkOutput("rst.ack",     {24'h0, txQ[0]}, 32'h06);
        checkOutput("rst.weCount", weCount, weBefore + 1);
        checkOutput("rst.addr",    {2'h0, weAddr}, 32'h3);
        checkOutput("rst.wdata",   weData, 32'h11223344);
        checkOutput("rst.mem",     mem[3], 32'h11223344);
        checkOutput("rst.oldMem",  mem[4], 32'h12345678);

        repeat (3) tick();
        checkOutput("txHold",    stableErrs, 0);
        checkOutput("gntProto",  gntViolations, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
